// File: rtl/regfile_clr.sv
// Register file with two async read ports, one write port and a post-reset clear sequencer.
// Optional same-cycle write-to-read forwarding under REGFILE_BYPASS_EN.
module regfile_clr #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] reg1_addr,
  input  logic [ADDR_W-1:0] reg2_addr,
  input  logic [ADDR_W-1:0] dstreg_addr,
  input  logic              write_reg,
  input  logic [DATA_W-1:0] dstreg_data,
  output logic [DATA_W-1:0] reg1_data,
  output logic [DATA_W-1:0] reg2_data,
  output logic              ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;

  assign wr_ok = (state == IDLE) && write_reg &&
                 !(ZERO_REG != 0 && dstreg_addr == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        IDLE: ;
        default: state <= CLEAR;
      endcase
    end
  end

  // Array has no reset; the sequencer zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR)
        mem[cnt] <= '0;
      else if (wr_ok)
        mem[dstreg_addr] <= dstreg_data;
    end
  end

  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    if (ready && !(ZERO_REG != 0 && a == '0)) begin
`ifdef REGFILE_BYPASS_EN
      if (write_reg && a == dstreg_addr)
        v = dstreg_data;
      else
        v = mem[a];
`else
      v = mem[a];
`endif
    end
    return v;
  endfunction

  always_comb begin
    reg1_data = rd(reg1_addr);
    reg2_data = rd(reg2_addr);
  end

endmodule

// File: tb/tb_regfile_clr.sv
// Directed bench for regfile_clr: clear sequence, write/read table,
// writes during clear, reset mid-clear, bypass and a small-parameter instance.
module tb_regfile_clr;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  reg1_addr, reg2_addr, dstreg_addr;
  logic        write_reg;
  logic [31:0] dstreg_data, reg1_data, reg2_data;
  logic        ready;

  logic [2:0]  s_a1, s_a2, s_wa;
  logic        s_we;
  logic [15:0] s_wd, s_d1, s_d2;
  logic        s_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_clr dut (
    .clk(clk), .rst(rst),
    .reg1_addr(reg1_addr), .reg2_addr(reg2_addr),
    .dstreg_addr(dstreg_addr), .write_reg(write_reg),
    .dstreg_data(dstreg_data),
    .reg1_data(reg1_data), .reg2_data(reg2_data),
    .ready(ready)
  );

  regfile_clr #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) dut16 (
    .clk(clk), .rst(rst),
    .reg1_addr(s_a1), .reg2_addr(s_a2),
    .dstreg_addr(s_wa), .write_reg(s_we),
    .dstreg_data(s_wd),
    .reg1_data(s_d1), .reg2_data(s_d2),
    .ready(s_ready)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after reset release until ready; also checks reads stay 0.
  task automatic wait_ready(input string name, input logic wr_noise);
    int n = 0;
    int n16 = -1;
    reg1_addr = 5'd3;
    reg2_addr = 5'd7;
    while (!ready && n < 100) begin
      write_reg   = wr_noise;
      dstreg_addr = 5'd3;
      dstreg_data = 32'hAAAA5555;
      if (n == 0) chk({name, "_ready0"}, {31'd0, ready}, 32'd0);
      if (reg1_data !== 32'd0 || reg2_data !== 32'd0)
        chk({name, "_rd_in_clear"}, reg1_data | reg2_data, 32'd0);
      step();
      n++;
      if (s_ready && n16 < 0) n16 = n;
    end
    write_reg = 1'b0;
    chk({name, "_latency"}, 32'(n), 32'd32);
    chk({name, "_latency16"}, 32'(n16), 32'd8);
  endtask

  task automatic check_all_zero(input string name);
    logic [31:0] acc = '0;
    for (int i = 0; i < 32; i++) begin
      reg1_addr = 5'(i);
      reg2_addr = 5'(31 - i);
      #1;
      acc = acc | reg1_data | reg2_data;
    end
    chk(name, acc, 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd7,  32'hDEADBEEF, 5'd7,  5'd7,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 5'd31, 32'h12345678, 5'd7,  5'd31, 32'hDEADBEEF, 32'h12345678};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd31, 32'h0,        32'h12345678};
    vecs[3] = '{1'b0, 5'd7,  32'h00000055, 5'd31, 5'd7,  32'h12345678, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 5'd1,  32'h00000001, 5'd1,  5'd3,  32'h1,        32'h0};
    vecs[5] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd1,  32'hCAFEF00D, 32'h1};

    rst = 1'b1; write_reg = 1'b0;
    reg1_addr = '0; reg2_addr = '0; dstreg_addr = '0; dstreg_data = '0;
    s_a1 = '0; s_a2 = '0; s_wa = '0; s_we = 1'b0; s_wd = '0;
    step(); step();
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_rd", reg1_data, 32'd0);
    rst = 1'b0;

    wait_ready("clear1", 1'b1);
    chk("ready_up", {31'd0, ready}, 32'd1);
    check_all_zero("clear1_zero");
    reg1_addr = 5'd3; #1;
    chk("r3_after_noise", reg1_data, 32'd0);

    for (int i = 0; i < 6; i++) begin
      write_reg   = vecs[i].we;
      dstreg_addr = vecs[i].wa;
      dstreg_data = vecs[i].wd;
      step();
      write_reg = 1'b0;
      reg1_addr = vecs[i].a1;
      reg2_addr = vecs[i].a2;
      #1;
      chk($sformatf("vec%0d_r1", i), reg1_data, vecs[i].e1);
      chk($sformatf("vec%0d_r2", i), reg2_data, vecs[i].e2);
    end

    write_reg = 1'b1; dstreg_addr = 5'd5; dstreg_data = 32'h11;
    step();
    dstreg_data = 32'h22; reg1_addr = 5'd5; reg2_addr = 5'd5;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_pre_r1", reg1_data, 32'h22);
    chk("byp_pre_r2", reg2_data, 32'h22);
`else
    chk("byp_pre_r1", reg1_data, 32'h11);
    chk("byp_pre_r2", reg2_data, 32'h11);
`endif
    step();
    write_reg = 1'b0;
    chk("byp_post_r1", reg1_data, 32'h22);
    chk("byp_post_r2", reg2_data, 32'h22);
    write_reg = 1'b1; dstreg_addr = 5'd0; dstreg_data = 32'h33;
    reg1_addr = 5'd0;
    #1;
    chk("byp_r0", reg1_data, 32'd0);
    write_reg = 1'b0;

    for (int i = 1; i < 32; i++) begin
      write_reg = 1'b1; dstreg_addr = 5'(i); dstreg_data = 32'(i);
      step();
    end
    write_reg = 1'b0;
    reg1_addr = 5'd17; reg2_addr = 5'd30; #1;
    chk("fill_r17", reg1_data, 32'd17);
    chk("fill_r30", reg2_data, 32'd30);

    rst = 1'b1; step(); rst = 1'b0;
    chk("idle_rst_ready", {31'd0, ready}, 32'd0);
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1; step(); rst = 1'b0;
    wait_ready("clear2", 1'b0);
    check_all_zero("clear2_zero");

    s_we = 1'b1; s_wa = 3'd0; s_wd = 16'hBEEF;
    step();
    s_we = 1'b0; s_a1 = 3'd0; s_a2 = 3'd5; #1;
    chk("p16_r0", {16'd0, s_d1}, 32'h0000BEEF);
    chk("p16_r5", {16'd0, s_d2}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
